// File: rtl/eth_hdr_insert.sv
// Ethernet II header inserter for an AXI-stream packet path.
// Prepends dst MAC, src MAC and ethertype to each payload frame and shifts
// the payload across lane boundaries through a small carry register.
// A per-frame bypass mode forwards frames untouched.
module eth_hdr_insert #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_insert_en,
    input  logic [47:0]             cfg_mac_dst,
    input  logic [47:0]             cfg_mac_src,
    input  logic [15:0]             cfg_ethertype,
    input  logic [DATA_WIDTH-1:0]   stream_in_DATA,
    input  logic [DATA_WIDTH/8-1:0] stream_in_KEEP,
    input  logic                    stream_in_LAST,
    input  logic                    stream_in_VALID,
    output logic                    stream_in_READY,
    output logic [DATA_WIDTH-1:0]   stream_out_DATA,
    output logic [DATA_WIDTH/8-1:0] stream_out_KEEP,
    output logic                    stream_out_LAST,
    output logic                    stream_out_VALID,
    input  logic                    stream_out_READY,
    output logic [31:0]             frame_cnt
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int OFS    = 14 % KEEP_W;
    localparam int NHF    = 14 / KEEP_W;
    localparam int HB     = NHF * KEEP_W;
    localparam int CW     = OFS * 8;

    typedef enum logic [2:0] {IDLE, HDR, BODY, TAIL, BYPASS} state_t;

    state_t                  state, state_n;
    logic [13:0][7:0]        hdr_fresh;
    logic [DATA_WIDTH-1:0]   hdr_flit_fresh, hdr_flit_q, hdr_flit_n;
    logic [CW-1:0]           carry, carry_n;
    logic [OFS-1:0]          carry_keep, carry_keep_n;
    logic                    adv, in_hs;
    logic                    valid_n, last_n;
    logic [DATA_WIDTH-1:0]   data_n, data_masked;
    logic [KEEP_W-1:0]       keep_n;

    // The output register may take a new flit when it is empty or being drained.
    assign adv             = !stream_out_VALID || stream_out_READY;
    assign stream_in_READY = ((state == BODY) || (state == BYPASS)) && adv;
    assign in_hs           = stream_in_VALID && stream_in_READY;

    // Header bytes in wire order: byte k of the header lands on frame byte k.
    always_comb begin
        hdr_fresh = '0;
        for (int k = 0; k < 6; k++) begin
            hdr_fresh[k]     = cfg_mac_dst[47-8*k -: 8];
            hdr_fresh[6 + k] = cfg_mac_src[47-8*k -: 8];
        end
        hdr_fresh[12] = cfg_ethertype[15:8];
        hdr_fresh[13] = cfg_ethertype[7:0];
    end

    // Only narrow buses need a whole flit of pure header ahead of the payload.
    generate
        if (NHF > 0) begin : g_hdr_flit
            assign hdr_flit_fresh = hdr_fresh[KEEP_W-1:0];
        end else begin : g_no_hdr_flit
            assign hdr_flit_fresh = '0;
        end
    endgenerate

    // Next-state and next-output decision for the framing FSM.
    always_comb begin
        state_n      = state;
        carry_n      = carry;
        carry_keep_n = carry_keep;
        hdr_flit_n   = hdr_flit_q;
        valid_n      = 1'b0;
        last_n       = 1'b0;
        data_n       = '0;
        keep_n       = '0;
        case (state)
            IDLE: begin
                if (stream_in_VALID) begin
                    hdr_flit_n = hdr_flit_fresh;
                    if (cfg_insert_en) begin
                        carry_n      = hdr_fresh[13:HB];
                        carry_keep_n = '1;
                        state_n      = (NHF > 0) ? HDR : BODY;
                    end else begin
                        state_n = BYPASS;
                    end
                end
            end
            HDR: begin
                if (adv) begin
                    valid_n = 1'b1;
                    data_n  = hdr_flit_q;
                    keep_n  = '1;
                    state_n = BODY;
                end
            end
            BODY: begin
                if (in_hs) begin
                    valid_n      = 1'b1;
                    data_n       = {stream_in_DATA[DATA_WIDTH-CW-1:0], carry};
                    keep_n       = {stream_in_KEEP[KEEP_W-OFS-1:0], {OFS{1'b1}}};
                    carry_n      = stream_in_DATA[DATA_WIDTH-1 -: CW];
                    carry_keep_n = stream_in_KEEP[KEEP_W-1 -: OFS];
                    if (stream_in_LAST) begin
                        if (|stream_in_KEEP[KEEP_W-1 -: OFS]) begin
                            state_n = TAIL;
                        end else begin
                            last_n  = 1'b1;
                            state_n = IDLE;
                        end
                    end
                end
            end
            TAIL: begin
                if (adv) begin
                    valid_n = 1'b1;
                    data_n  = {{(DATA_WIDTH-CW){1'b0}}, carry};
                    keep_n  = {{(KEEP_W-OFS){1'b0}}, carry_keep};
                    last_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            BYPASS: begin
                if (in_hs) begin
                    valid_n = 1'b1;
                    data_n  = stream_in_DATA;
                    keep_n  = stream_in_KEEP;
                    last_n  = stream_in_LAST;
                    if (stream_in_LAST) begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Lanes without a byte enable always carry zero on the wire.
    always_comb begin
        data_masked = data_n;
        for (int l = 0; l < KEEP_W; l++) begin
            if (!keep_n[l]) begin
                data_masked[8*l +: 8] = 8'h00;
            end
        end
    end

    // State, carry and output registers; outputs hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            carry            <= '0;
            carry_keep       <= '0;
            hdr_flit_q       <= '0;
            stream_out_VALID <= 1'b0;
            stream_out_LAST  <= 1'b0;
            stream_out_DATA  <= '0;
            stream_out_KEEP  <= '0;
        end else begin
            state      <= state_n;
            carry      <= carry_n;
            carry_keep <= carry_keep_n;
            hdr_flit_q <= hdr_flit_n;
            if (adv) begin
                stream_out_VALID <= valid_n;
                stream_out_LAST  <= last_n;
                stream_out_DATA  <= data_masked;
                stream_out_KEEP  <= keep_n;
            end
        end
    end

    // Count frames as their final flit is accepted downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (stream_out_VALID && stream_out_READY && stream_out_LAST) begin
            frame_cnt <= frame_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_eth_hdr_insert.sv
// Bench for eth_hdr_insert: directed known-answer frames, randomized
// frames with back-pressure checked against a byte-stream reference model,
// bypass, mid-frame reset, and a 128-bit instance.
module tb_eth_hdr_insert;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cfg_insert_en;
    logic [47:0] cfg_mac_dst, cfg_mac_src;
    logic [15:0] cfg_ethertype;

    logic [63:0] in_data;
    logic [7:0]  in_keep;
    logic        in_last, in_valid, in_ready;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic        out_last, out_valid, out_ready;
    logic [31:0] frame_cnt;

    logic [127:0] w_in_data, w_out_data;
    logic [15:0]  w_in_keep, w_out_keep;
    logic         w_in_last, w_in_valid, w_in_ready;
    logic         w_out_last, w_out_valid, w_out_ready;
    logic [31:0]  w_frame_cnt;

    eth_hdr_insert #(.DATA_WIDTH(64)) u_dut (
        .clk(clk), .rst(rst),
        .cfg_insert_en(cfg_insert_en), .cfg_mac_dst(cfg_mac_dst),
        .cfg_mac_src(cfg_mac_src), .cfg_ethertype(cfg_ethertype),
        .stream_in_DATA(in_data), .stream_in_KEEP(in_keep),
        .stream_in_LAST(in_last), .stream_in_VALID(in_valid),
        .stream_in_READY(in_ready),
        .stream_out_DATA(out_data), .stream_out_KEEP(out_keep),
        .stream_out_LAST(out_last), .stream_out_VALID(out_valid),
        .stream_out_READY(out_ready), .frame_cnt(frame_cnt)
    );

    eth_hdr_insert #(.DATA_WIDTH(128)) u_dut128 (
        .clk(clk), .rst(rst),
        .cfg_insert_en(cfg_insert_en), .cfg_mac_dst(cfg_mac_dst),
        .cfg_mac_src(cfg_mac_src), .cfg_ethertype(cfg_ethertype),
        .stream_in_DATA(w_in_data), .stream_in_KEEP(w_in_keep),
        .stream_in_LAST(w_in_last), .stream_in_VALID(w_in_valid),
        .stream_in_READY(w_in_ready),
        .stream_out_DATA(w_out_data), .stream_out_KEEP(w_out_keep),
        .stream_out_LAST(w_out_last), .stream_out_VALID(w_out_valid),
        .stream_out_READY(w_out_ready), .frame_cnt(w_frame_cnt)
    );

    typedef struct { logic [63:0]  d; logic [7:0]  k; logic l; } flit_t;
    typedef struct { logic [127:0] d; logic [15:0] k; logic l; } flit128_t;

    flit_t      out_log[$];
    flit128_t   log128[$];
    logic [7:0] exp_bytes[$];
    int         exp_lens[$];
    int         model_frames = 0;
    int         comp_count = 0;
    int         fail_count = 0;
    bit         rand_mode = 1'b0;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        comp_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference header: byte k of the Ethernet II header as it appears on the wire.
    function automatic logic [7:0] hdrByte(input int k, input logic [47:0] dst,
                                           input logic [47:0] src, input logic [15:0] et);
        if (k < 6)       return 8'(dst >> (8 * (5 - k)));
        else if (k < 12) return 8'(src >> (8 * (11 - k)));
        else if (k == 12) return et[15:8];
        else             return et[7:0];
    endfunction

    // Downstream ready: always high, or a coin toss per cycle in random mode.
    initial begin
        out_ready   = 1'b1;
        w_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: logs accepted flits and checks stability while stalled.
    flit_t held;
    bit    stalled = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checkOutput("stall_data", out_data, held.d);
                checkOutput("stall_ctrl", {out_valid, out_keep, out_last}, {1'b1, held.k, held.l});
            end
            stalled = out_valid && !out_ready;
            held.d  = out_data;
            held.k  = out_keep;
            held.l  = out_last;
            if (out_valid && out_ready) out_log.push_back('{out_data, out_keep, out_last});
            if (w_out_valid && w_out_ready) log128.push_back('{w_out_data, w_out_keep, w_out_last});
        end
    end

    // Drive one frame and record the byte stream the model says must come out.
    task automatic applyStimulus(input bit insert, input int n_flits, input int last_bytes,
                                 input logic [47:0] dst, input logic [47:0] src,
                                 input logic [15:0] et, input bit seq_data, input bit gaps);
        int nb;
        int t;
        logic [7:0] b;
        @(posedge clk);
        #1;
        cfg_insert_en = insert;
        cfg_mac_dst   = dst;
        cfg_mac_src   = src;
        cfg_ethertype = et;
        if (insert) for (int k = 0; k < 14; k++) exp_bytes.push_back(hdrByte(k, dst, src, et));
        exp_lens.push_back((insert ? 14 : 0) + (n_flits - 1) * 8 + last_bytes);
        model_frames++;
        for (int f = 0; f < n_flits; f++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            nb = (f == n_flits - 1) ? last_bytes : 8;
            for (int i = 0; i < 8; i++) begin
                b = seq_data ? 8'(f * 8 + i) : 8'($urandom);
                if (i < nb) exp_bytes.push_back(b);
                else b = 8'($urandom);
                in_data[8*i +: 8] = b;
            end
            in_keep  = 8'((9'd1 << nb) - 9'd1);
            in_last  = (f == n_flits - 1);
            in_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 3000) checkOutput("in_ready_timeout", 64'(t), 64'd0);
            @(posedge clk);
            #1;
            if (f == 0) begin
                cfg_insert_en = 1'($urandom);
                cfg_mac_dst   = {16'($urandom), $urandom};
                cfg_mac_src   = {16'($urandom), $urandom};
                cfg_ethertype = 16'($urandom);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) until the frame counter reaches its model value.
    task automatic waitFrames(input int target);
        int t = 0;
        while (frame_cnt != 32'(target) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        checkOutput("frame_cnt", 64'(frame_cnt), 64'(target));
        repeat (3) @(negedge clk);
    endtask

    // Model: each frame's bytes pack densely into 8-byte flits, LAST on the final one.
    task automatic checkLog();
        flit_t       fl;
        int          n, rem, cnt;
        logic [63:0] ed;
        logic [7:0]  ek;
        while (exp_lens.size() > 0) begin
            n = exp_lens.pop_front();
            for (int pos = 0; pos < n; pos += 8) begin
                rem = n - pos;
                cnt = (rem > 8) ? 8 : rem;
                ed  = '0;
                for (int b = 0; b < cnt; b++) ed[8*b +: 8] = exp_bytes.pop_front();
                ek = 8'((9'd1 << cnt) - 9'd1);
                if (out_log.size() == 0) begin
                    checkOutput("flit_missing", 64'd0, 64'd1);
                end else begin
                    fl = out_log.pop_front();
                    checkOutput("out_data", fl.d, ed);
                    checkOutput("out_keep", 64'(fl.k), 64'(ek));
                    checkOutput("out_last", 64'(fl.l), 64'(rem <= 8));
                end
            end
        end
        checkOutput("extra_flits", 64'(out_log.size()), 64'd0);
        out_log.delete();
    endtask

    localparam logic [47:0] DST = 48'hfa163e55ca02;
    localparam logic [47:0] SRC = 48'h0cc47a88c047;

    initial begin
        #700000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        rst = 1'b1;
        cfg_insert_en = 1'b1; cfg_mac_dst = '0; cfg_mac_src = '0; cfg_ethertype = '0;
        in_data = '0; in_keep = '0; in_last = 1'b0; in_valid = 1'b0;
        w_in_data = '0; w_in_keep = '0; w_in_last = 1'b0; w_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_last", 64'(out_last), 64'd0);
        checkOutput("reset_data", out_data, 64'd0);
        checkOutput("reset_keep", 64'(out_keep), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset_frame_cnt", 64'(frame_cnt), 64'd0);

        $display("[TB] known-answer frame, full payload flit");
        applyStimulus(1'b1, 1, 8, DST, SRC, 16'h0800, 1'b1, 1'b0);
        waitFrames(model_frames);
        checkOutput("t1_flit_count", 64'(out_log.size()), 64'd3);
        if (out_log.size() == 3) begin
            checkOutput("t1_f0_data", out_log[0].d, 64'hc40c02ca553e16fa);
            checkOutput("t1_f0_ctrl", {out_log[0].k, out_log[0].l}, {8'hff, 1'b0});
            checkOutput("t1_f1_data", out_log[1].d, 64'h0100000847c0887a);
            checkOutput("t1_f1_ctrl", {out_log[1].k, out_log[1].l}, {8'hff, 1'b0});
            checkOutput("t1_f2_data", out_log[2].d, 64'h0000070605040302);
            checkOutput("t1_f2_ctrl", {out_log[2].k, out_log[2].l}, {8'h3f, 1'b1});
        end
        checkLog();

        $display("[TB] known-answer frame, two payload bytes");
        applyStimulus(1'b1, 1, 2, DST, SRC, 16'h0800, 1'b1, 1'b0);
        waitFrames(model_frames);
        checkOutput("t2_flit_count", 64'(out_log.size()), 64'd2);
        if (out_log.size() == 2) begin
            checkOutput("t2_f1_data", out_log[1].d, 64'h0100000847c0887a);
            checkOutput("t2_f1_ctrl", {out_log[1].k, out_log[1].l}, {8'hff, 1'b1});
        end
        checkLog();

        $display("[TB] bypass frame");
        applyStimulus(1'b0, 3, 8, DST, SRC, 16'h0800, 1'b0, 1'b0);
        waitFrames(model_frames);
        checkLog();

        $display("[TB] randomized frames with back-pressure");
        rand_mode = 1'b1;
        for (int fr = 0; fr < 100; fr++) begin
            applyStimulus($urandom_range(0, 4) != 0, $urandom_range(1, 64), $urandom_range(1, 8),
                          {16'($urandom), $urandom}, {16'($urandom), $urandom},
                          16'($urandom), 1'b0, 1'b1);
        end
        waitFrames(model_frames);
        rand_mode = 1'b0;
        repeat (2) @(negedge clk);
        checkLog();

        $display("[TB] reset during body");
        @(posedge clk);
        #1;
        cfg_insert_en = 1'b1;
        in_data  = {$urandom, $urandom};
        in_keep  = 8'hff;
        in_last  = 1'b0;
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_mid_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_mid_frame_cnt", 64'(frame_cnt), 64'd0);
        out_log.delete();
        model_frames = 0;
        applyStimulus(1'b1, 2, 5, DST, SRC, 16'h86dd, 1'b0, 1'b0);
        waitFrames(model_frames);
        checkLog();

        $display("[TB] 128-bit instance, one 16-byte flit");
        @(posedge clk);
        #1;
        cfg_insert_en = 1'b1; cfg_mac_dst = DST; cfg_mac_src = SRC; cfg_ethertype = 16'h0800;
        for (int i = 0; i < 16; i++) w_in_data[8*i +: 8] = 8'(i);
        w_in_keep = 16'hffff; w_in_last = 1'b1; w_in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!w_in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) checkOutput("w128_in_ready_timeout", 64'(t), 64'd0);
        @(posedge clk);
        #1 w_in_valid = 1'b0;
        t = 0;
        while (w_frame_cnt != 32'd1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        checkOutput("w128_frame_cnt", 64'(w_frame_cnt), 64'd1);
        checkOutput("w128_flit_count", 64'(log128.size()), 64'd2);
        if (log128.size() == 2) begin
            logic [127:0] e0, e1;
            for (int l = 0; l < 14; l++) e0[8*l +: 8] = hdrByte(l, DST, SRC, 16'h0800);
            e0[127:112] = 16'h0100;
            e1 = '0;
            for (int l = 0; l < 14; l++) e1[8*l +: 8] = 8'(l + 2);
            checkOutput("w128_f0_lo", log128[0].d[63:0], e0[63:0]);
            checkOutput("w128_f0_hi", log128[0].d[127:64], e0[127:64]);
            checkOutput("w128_f0_ctrl", {log128[0].k, log128[0].l}, {16'hffff, 1'b0});
            checkOutput("w128_f1_lo", log128[1].d[63:0], e1[63:0]);
            checkOutput("w128_f1_hi", log128[1].d[127:64], e1[127:64]);
            checkOutput("w128_f1_ctrl", {log128[1].k, log128[1].l}, {16'h3fff, 1'b1});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_count, fail_count);
        $finish;
    end

endmodule

// File: doc/eth_hdr_insert.md
# eth_hdr_insert

Synthesizable AXI-stream Ethernet header inserter for the shell's packet path, parametrised in bus width. It prepends a 14-byte Ethernet II header (destination MAC, source MAC, ethertype) to each payload frame, shifting the payload across lane boundaries as needed. A per-frame bypass mode passes frames through unmodified. It replaces the fixed 64-bit testbench header task with hardware usable in both simulation and the shell.

## Interface
- DATA_WIDTH, 64: stream width in bits; legal values are 64, 128 and 256. KEEP_W = DATA_WIDTH/8.
- OFS (derived, not overridable): 14 mod KEEP_W. This is 6 for 64-bit, 14 for 128 and 256.
- NHF (derived): floor(14/KEEP_W), the number of all-header flits. This is 1 for 64-bit, 0 otherwise.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- cfg_insert_en  in  1  1 = insert header, 0 = bypass. Sampled per frame.
- cfg_mac_dst  in  48  destination MAC.
- cfg_mac_src  in  48  source MAC.
- cfg_ethertype  in  16  ethertype.
- stream_in_DATA  in  DATA_WIDTH  payload data; byte n on lane n (DATA[8n+7:8n]).
- stream_in_KEEP  in  KEEP_W  byte enables; contiguous from lane 0 and nonzero.
- stream_in_LAST  in  1  last payload flit of the frame.
- stream_in_VALID  in  1  input valid.
- stream_in_READY  out  1  input ready.
- stream_out_DATA  out  DATA_WIDTH  framed data.
- stream_out_KEEP  out  KEEP_W  byte enables.
- stream_out_LAST  out  1  last flit of the frame.
- stream_out_VALID  out  1  output valid.
- stream_out_READY  in  1  output ready.
- frame_cnt  out  32  count of output frames completed; wraps.

## Operation
- Header byte order on the wire: dst[47:40] first through dst[7:0], then src[47:40] through src[7:0], then ethertype[15:8], ethertype[7:0]. Header byte k goes to frame byte k.
- FSM states: IDLE, HDR, BODY, TAIL, BYPASS.
- IDLE
  - No input is consumed.
  - When stream_in_VALID = 1, latch all cfg_* inputs.
  - If insert is enabled, go to HDR when NHF > 0, else to BODY. Preload the carry register with header bytes NHF·KEEP_W..13 (OFS bytes) and set carry keep to all ones.
  - If insert is disabled, go to BYPASS.
- HDR
  - Emit NHF flits of header bytes: KEEP all ones, LAST = 0. No input is consumed.
  - Then go to BODY.
- BODY, on each input handshake, emit one flit:
  - Lanes 0..OFS-1 take the carry bytes.
  - Lanes OFS..KEEP_W-1 take input lanes 0..KEEP_W-1-OFS.
  - KEEP = {in_KEEP[KEEP_W-1-OFS:0], OFS ones}.
  - Carry is updated to input lanes KEEP_W-OFS..KEEP_W-1, with carry keep = in_KEEP[KEEP_W-1:KEEP_W-OFS].
  - On stream_in_LAST, if any bit of the new carry keep is set, output LAST = 0 and go to TAIL. Otherwise output LAST = 1 and go to IDLE.
- TAIL
  - Emit the carry in lanes 0..OFS-1 with KEEP = carry keep; upper lanes are zero data and zero keep. LAST = 1. No input is consumed.
  - Then go to IDLE.
- BYPASS
  - Input flits are copied to the output unchanged.
  - On the accepted LAST flit, go to IDLE.
- Data bytes on lanes with KEEP = 0 are driven to zero.
- cfg_* changes mid-frame have no effect until the next IDLE latch.
- frame_cnt increments on every accepted output flit with LAST = 1, in both insert and bypass modes. It wraps from 0xFFFFFFFF to 0.

## Timing
- Output is fully registered. stream_out_* remain stable while VALID = 1 and READY = 0.
- stream_in_READY = (!stream_out_VALID || stream_out_READY), and only in BODY or BYPASS. It is 0 in IDLE, HDR and TAIL.
- Latency: the first output flit is valid 2 cycles after stream_in_VALID rises in IDLE (1 cycle for the IDLE decision, 1 cycle for the register).
- Throughput: a steady-state flit rate of 1 per cycle with READY held high.
- Per-frame overhead: 1 IDLE cycle + NHF cycles + 1 TAIL cycle when TAIL is taken.
- Reset values: stream_out_VALID = 0, stream_out_LAST = 0, stream_out_DATA = 0, stream_out_KEEP = 0, stream_in_READY = 0, frame_cnt = 0, state = IDLE, carry = 0.
- Reset mid-frame:
  - The partial frame is abandoned and no LAST is emitted.
  - VALID drops on the cycle after rst is sampled high.
  - Upstream must restart at a frame boundary.

## Test plan
1. 64-bit, dst=fa163e55ca02, src=0cc47a88c047, type=0x0800, one input flit 0x0706050403020100 with KEEP=ff, LAST=1. Required output:
   - flit 0: 0xc40c02ca553e16fa, KEEP=ff, LAST=0.
   - flit 1: 0x0100000847c0887a, KEEP=ff, LAST=0.
   - flit 2: 0x0000070605040302, KEEP=3f, LAST=1.
   - frame_cnt = 1.
2. Same header, input 0x0000000000000100 with KEEP=03, LAST=1 → exactly 2 output flits. The second is 0x0100000847c0887a, KEEP=ff, LAST=1, and TAIL is not entered.
3. 64-bit, 100 random frames (1–64 flits, random final KEEP), with stream_out_READY toggled randomly at 50% and input VALID gaps → the output byte stream equals header + payload per frame, with no data change while stalled.
4. cfg_insert_en=0, 3-flit frame → output is identical to the input, frame_cnt += 1. cfg_insert_en toggled mid-frame → no effect on the current frame.
5. rst asserted during BODY → VALID = 0 and READY = 0 the next cycle. The next frame after reset is emitted correctly with header flit 0 first.
6. DATA_WIDTH=128, one 16-byte input flit with LAST=1 → flit 0 carries the 14 header bytes plus payload bytes 0–1 with KEEP=ffff. Flit 1 carries payload bytes 2–15 with KEEP=3fff, LAST=1.
